data_mem_responder: RTL and testbench
=====================================

# data_mem_responder

Memory-side responder for CPU data accesses. Accepts load/store requests over a req/ack handshake, inserts a fixed number of wait states, then performs a big-endian 32-bit access on a byte-addressed array and acknowledges. Sits between the multicycle CPU datapath (the initiator: ALU result as address, register B as write data) and the data storage. It replaces the zero-latency, combinational-read memory with a timed, handshaked slave.

## Interface
Parameters:
- ADDR_W, 8, byte-address width; storage depth 2^ADDR_W bytes
- WAIT_CYCLES, 2, wait states inserted before the access (0 allowed)

Ports (`clk` is the single clock; `Reset` is asynchronous and active-low):
- clk  in  1  single clock, rising-edge
- Reset  in  1  asynchronous, active-low reset
- req  in  1  request; sampled only in IDLE
- we  in  1  1 = store, 0 = load; captured with req
- addr  in  32  byte address; bits above ADDR_W-1 ignored
- wdata  in  32  store data; captured with req
- rdata  out  32  load data; valid only while ack=1; reset 0
- ack  out  1  one-cycle completion pulse; reset 0
- err  out  1  misaligned-access flag; valid with ack; reset 0 (tied 0 without DMEM_ALIGN_CHECK_EN)

## Operation
- States: IDLE, WAIT, RESP.
- IDLE, req=1 at a rising edge:
  - capture we, addr[ADDR_W-1:0] and wdata;
  - load cnt <= WAIT_CYCLES;
  - go to WAIT.
- WAIT:
  - cnt != 0: cnt--.
  - cnt == 0: perform the access, ack<=1, go to RESP.
    - Store: mem[a]<=wdata[31:24], mem[a+1]<=[23:16], mem[a+2]<=[15:8], mem[a+3]<=[7:0].
    - Load: rdata<={mem[a],mem[a+1],mem[a+2],mem[a+3]}.
- RESP: ack<=0, rdata<=0, err<=0, go to IDLE.
- Byte index arithmetic a+k is modulo 2^ADDR_W: an access at the top of memory wraps to byte 0.
- Inputs are captured once. Changes to req, addr, we or wdata during WAIT/RESP are ignored; dropping req mid-transaction does not abort it.
- A req still high in the IDLE cycle after RESP starts a new transaction. Back-to-back requests are legal.
- Store: rdata stays 0 during its ack.
- Memory array has no reset. Contents survive Reset; initial contents are undefined (zero in simulation).

## Timing
- Sampling edge = edge E0. ack rises at edge E0+WAIT_CYCLES+1 and falls at the following edge. ack is high for exactly 1 cycle.
- Minimum request-to-request period: WAIT_CYCLES+3 cycles.
- Store data is visible to a load whose access edge is later than the store's access edge.
- Reset asserted mid-transaction:
  - immediately: state=IDLE, ack=0, rdata=0, err=0, cnt=0;
  - the pending store is dropped if its access edge has not occurred;
  - no ack is ever produced for the aborted transaction.
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration
- DMEM_ALIGN_CHECK_EN defined:
  - a captured addr[1:0] != 0 completes with normal timing, with err=1 alongside ack;
  - no memory write occurs; rdata=0.
- Undefined:
  - addr[1:0] is forced to 0 at capture (word-aligned access);
  - err is constant 0.

## Structure
- Package dmem_pkg:
  - state enum (IDLE, WAIT, RESP);
  - byte-lane constants (lane 0 = bits 31:24);
  - default ADDR_W and WAIT_CYCLES values.
- One sub-module, dmem_byte_array:
  - 2^ADDR_W x 8 storage;
  - four byte-lane write-enables, combinational 4-byte big-endian read at a base index with modulo wrap.
- FSM, counter, capture registers and alignment check live in data_mem_responder.

## Test plan
- Store then load, WAIT_CYCLES=2: store 0x12345678 at 0x10, then load 0x10 -> rdata=0x12345678. Byte 0x10 holds 0x12 and 0x13 holds 0x78. Each ack rises exactly 3 edges after its sampling edge.
- WAIT_CYCLES=0: load 0x20 -> ack one edge after the sampling edge. Holding req high -> a new ack every 3 cycles.
- Wrap, ADDR_W=8: store 0xAABBCCDD at 0xFC, load 0xFC -> 0xAABBCCDD. Then load 0x00 -> lanes from 0x00..0x03, unchanged by the wrap store.
- Misaligned 0x11:
  - macro on: store 0xFFFFFFFF -> ack with err=1, and a load of 0x10 shows the old data.
  - macro off: the access goes to 0x10.
- Reset mid-WAIT of a store 0xDEADBEEF at 0x40: ack and rdata go 0 immediately, no ack follows, and a later load of 0x40 returns the prior contents.
- req dropped right after sampling, addr changed to 0x80 during WAIT: the access still targets the captured address and exactly one ack occurs.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data memory responder: FSM states,
// big-endian byte-lane helpers and default geometry.
`timescale 1ns/1ps
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  localparam int NUM_LANES           = 4;
  localparam int LANE_W              = 8;
  localparam int DEFAULT_ADDR_W      = 8;
  localparam int DEFAULT_WAIT_CYCLES = 2;

  // Lane 0 is the most significant byte (bits 31:24), lane 3 the least.
  function automatic int lane_msb(input int lane);
    return 31 - LANE_W * lane;
  endfunction

  function automatic logic [7:0] lane_byte(input logic [31:0] word, input int lane);
    return word[lane_msb(lane) -: LANE_W];
  endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Request/acknowledge bus between the CPU datapath (master) and the
// data memory responder (slave).
`timescale 1ns/1ps
interface data_mem_responder_if;

  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ack;
  logic        err;

  modport master (
    output req, we, addr, wdata,
    input  rdata, ack, err
  );

  modport slave (
    input  req, we, addr, wdata,
    output rdata, ack, err
  );

endinterface

// File: rtl/dmem_byte_array.sv
// Byte-addressed storage with four byte-lane write enables and a
// combinational big-endian 4-byte read; lane offsets wrap modulo the depth.
`timescale 1ns/1ps
module dmem_byte_array
  import dmem_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W
) (
  input  logic                 clk,
  input  logic [NUM_LANES-1:0] lane_we,
  input  logic [ADDR_W-1:0]    base,
  input  logic [31:0]          wdata,
  output logic [31:0]          rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [7:0] mem [DEPTH];

  // No reset on the array: contents persist across the responder's reset.
  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_LANES; k++) begin
      if (lane_we[k]) begin
        mem[base + ADDR_W'(k)] <= lane_byte(wdata, k);
      end
    end
  end

  always_comb begin
    rdata = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      rdata[lane_msb(k) -: LANE_W] = mem[base + ADDR_W'(k)];
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// Timed, handshaked data memory slave: captures a request, waits WAIT_CYCLES,
// then performs a big-endian word access and pulses ack for one cycle.
// Optional misalignment reporting is enabled by defining DMEM_ALIGN_CHECK_EN.
`timescale 1ns/1ps
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W      = DEFAULT_ADDR_W,
  parameter int WAIT_CYCLES = DEFAULT_WAIT_CYCLES
) (
  input logic                 clk,
  input logic                 Reset,
  data_mem_responder_if.slave bus
);

  localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic                 we_q;
  logic [ADDR_W-1:0]    addr_q;
  logic [31:0]          wdata_q;
  logic                 mis_q;
  logic                 ack_q;
  logic [31:0]          rdata_q;
  logic                 err_q;

  logic [ADDR_W-1:0]    cap_addr;
  logic                 cap_mis;
  logic                 access;
  logic [NUM_LANES-1:0] lane_we;
  logic [31:0]          array_rdata;
  logic                 unused_addr_bits;

  // Without the check, the low address bits are dropped so every access is word aligned.
`ifdef DMEM_ALIGN_CHECK_EN
  assign cap_addr = bus.addr[ADDR_W-1:0];
  assign cap_mis  = |bus.addr[1:0];
`else
  assign cap_addr = {bus.addr[ADDR_W-1:2], 2'b00};
  assign cap_mis  = 1'b0;
`endif

  assign unused_addr_bits = ^bus.addr;

  assign access  = (state == WAIT) && (cnt == '0);
  assign lane_we = (access && we_q && !mis_q) ? {NUM_LANES{1'b1}} : '0;

  dmem_byte_array #(
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk     (clk),
    .lane_we (lane_we),
    .base    (addr_q),
    .wdata   (wdata_q),
    .rdata   (array_rdata)
  );

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state   <= IDLE;
      cnt     <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      mis_q   <= 1'b0;
      ack_q   <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req) begin
            we_q    <= bus.we;
            addr_q  <= cap_addr;
            wdata_q <= bus.wdata;
            mis_q   <= cap_mis;
            cnt     <= CNT_W'(WAIT_CYCLES);
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            ack_q   <= 1'b1;
            err_q   <= mis_q;
            rdata_q <= (!we_q && !mis_q) ? array_rdata : '0;
            state   <= RESP;
          end
        end
        RESP: begin
          ack_q   <= 1'b0;
          rdata_q <= '0;
          err_q   <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ack   = ack_q;
  assign bus.rdata = rdata_q;
  assign bus.err   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: a byte-array reference model predicts
// each response, and a negedge monitor checks data, err and ack timing.
`timescale 1ns/1ps
module tb_data_mem_responder;
  import dmem_pkg::*;

  localparam int AW = 8;
  localparam int WC = 2;

  logic clk   = 1'b0;
  logic Reset = 1'b0;

  always #5 clk = ~clk;

  data_mem_responder_if bus  ();
  data_mem_responder_if bus0 ();

  data_mem_responder #(.ADDR_W(AW), .WAIT_CYCLES(WC)) u_dut (
    .clk   (clk),
    .Reset (Reset),
    .bus   (bus)
  );

  data_mem_responder #(.ADDR_W(AW), .WAIT_CYCLES(0)) u_dut0 (
    .clk   (clk),
    .Reset (Reset),
    .bus   (bus0)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    longint      t;
  } exp_t;

  exp_t       sb [$];
  logic [7:0] model_mem [256];
  int         checks   = 0;
  int         failures = 0;

  function automatic void check_output(input string name, input logic [31:0] act,
                                       input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%08h required=0x%08h", name, act, req);
    end
  endfunction

  // Reference behaviour: a 256-byte big-endian memory addressed modulo its size.
  function automatic exp_t model_access(input bit w, input logic [31:0] addr,
                                        input logic [31:0] wd);
    exp_t e;
    int   a   = int'(addr & 32'hFF);
    bit   mis = 1'b0;
`ifdef DMEM_ALIGN_CHECK_EN
    mis = (addr[1:0] != 2'b00);
`else
    a = a & ~3;
`endif
    e.rdata = '0;
    e.err   = mis;
    e.t     = 0;
    if (!mis) begin
      for (int k = 0; k < 4; k++) begin
        if (w) model_mem[(a + k) % 256] = wd[31 - 8*k -: 8];
        else   e.rdata = (e.rdata << 8) | 32'(model_mem[(a + k) % 256]);
      end
    end
    return e;
  endfunction

  task automatic apply_stimulus(input bit w, input logic [31:0] addr, input logic [31:0] wd,
                                input bit hold, input bit scramble);
    exp_t e;
    @(negedge clk);
    bus.req   = 1'b1;
    bus.we    = w;
    bus.addr  = addr;
    bus.wdata = wd;
    @(posedge clk);
    e   = model_access(w, addr, wd);
    e.t = $time + (WC + 1) * 10 + 5;
    sb.push_back(e);
    #1;
    if (!hold || scramble) bus.req = 1'b0;
    if (scramble) begin
      bus.addr  = 32'h80;
      bus.wdata = $urandom;
      bus.we    = ~w;
    end
    repeat (WC + 2) @(negedge clk);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (Reset) begin
      if (bus.ack) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_ack actual=1 required=0");
        end else begin
          e = sb.pop_front();
          check_output("rdata", bus.rdata, e.rdata);
          check_output("err", 32'(bus.err), 32'(e.err));
          check_output("ack_time", 32'($time), 32'(e.t));
        end
      end else begin
        check_output("idle_rdata", bus.rdata, 32'h0);
        check_output("idle_err", 32'(bus.err), 32'h0);
      end
    end
  end

  initial begin
    bit          w;
    bit          hold;
    bit          scr;
    logic [31:0] a;
    bus.req  = 1'b0; bus.we  = 1'b0; bus.addr  = '0; bus.wdata  = '0;
    bus0.req = 1'b0; bus0.we = 1'b0; bus0.addr = '0; bus0.wdata = '0;

    repeat (2) @(negedge clk);
    check_output("reset_ack", 32'(bus.ack), 32'h0);
    check_output("reset_rdata", bus.rdata, 32'h0);
    check_output("reset_err", 32'(bus.err), 32'h0);
    Reset = 1'b1;

    for (int i = 0; i < 64; i++) apply_stimulus(1'b1, 32'(i * 4), $urandom, 1'b0, 1'b0);

    apply_stimulus(1'b1, 32'h10, 32'h12345678, 1'b0, 1'b0);
    apply_stimulus(1'b0, 32'h10, 32'h0, 1'b0, 1'b0);
    apply_stimulus(1'b1, 32'hFC, 32'hAABBCCDD, 1'b0, 1'b0);
    apply_stimulus(1'b0, 32'hFC, 32'h0, 1'b0, 1'b0);
    apply_stimulus(1'b0, 32'h00, 32'h0, 1'b0, 1'b0);
    apply_stimulus(1'b1, 32'h11, 32'hFFFFFFFF, 1'b0, 1'b0);
    apply_stimulus(1'b0, 32'h10, 32'h0, 1'b0, 1'b0);
    apply_stimulus(1'b0, 32'hABCD0010, 32'h0, 1'b0, 1'b0);
    apply_stimulus(1'b1, 32'h30, 32'h5A5AA5A5, 1'b0, 1'b1);
    apply_stimulus(1'b0, 32'h30, 32'h0, 1'b0, 1'b0);
    apply_stimulus(1'b0, 32'h80, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) apply_stimulus(1'b0, $urandom, 32'h0, (i < 3), 1'b0);

    // Abort a store mid-wait; the array must keep its earlier word at 0x40.
    @(negedge clk);
    bus.req = 1'b1; bus.we = 1'b1; bus.addr = 32'h40; bus.wdata = 32'hDEADBEEF;
    @(posedge clk);
    #1 bus.req = 1'b0;
    @(negedge clk);
    #2 Reset = 1'b0;
    #1;
    check_output("abort_ack", 32'(bus.ack), 32'h0);
    check_output("abort_rdata", bus.rdata, 32'h0);
    check_output("abort_err", 32'(bus.err), 32'h0);
    repeat (2) @(negedge clk);
    Reset = 1'b1;
    repeat (8) @(negedge clk);
    apply_stimulus(1'b0, 32'h40, 32'h0, 1'b0, 1'b0);

    for (int i = 0; i < 150; i++) begin
      w    = 1'($urandom_range(0, 1));
      a    = $urandom;
      scr  = ($urandom_range(0, 7) == 0);
      hold = (i < 149) && ($urandom_range(0, 1) == 1);
      apply_stimulus(w, a, $urandom, hold, scr);
    end

    // Zero wait states with req held: ack one edge after sampling, then every 3 cycles.
    @(negedge clk);
    bus0.req = 1'b1; bus0.we = 1'b0; bus0.addr = 32'h20;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      check_output("w0_ack", 32'(bus0.ack), 32'((k % 3) == 2));
    end
    bus0.req = 1'b0;

    repeat (6) @(negedge clk);
    check_output("scoreboard_empty", 32'(sb.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
